// File: rtl/proc_pkg.sv
// Shared definitions for the 16-bit core and its instruction feeder:
// data width, opcodes and the fetch sequencer state encoding.
package proc_pkg;

  localparam int DATA_W = 16;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVT = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_WAIT,
    S_HALT,
    S_ERROR
  } fetch_state_e;

endpackage

// File: rtl/prog_ram.sv
// Program store: one write port, one registered read port.
// A read of the address being written returns the new word.
module prog_ram #(
  parameter int AW = 5,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
    rdata_q <= (we && waddr == raddr) ? wdata : mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/instr_fetch_seq.sv
// Feeds one instruction at a time to the core, waits for Done,
// and traps to ERROR if the core stalls too long.
import proc_pkg::*;

module instr_fetch_seq #(
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = proc_pkg::DATA_W,
  parameter int TIMEOUT = 8
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  input  logic [ADDR_W:0]   ProgLen,
  input  logic              ProgWe,
  input  logic [ADDR_W-1:0] ProgAddr,
  input  logic [DATA_W-1:0] ProgData,
  input  logic              Done,
  output logic [DATA_W-1:0] DIN,
  output logic              Run,
  output logic [ADDR_W-1:0] PC,
  output logic              Busy,
  output logic              Halted,
  output logic              Error
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

  fetch_state_e state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic              run_q, busy_q, halted_q, error_q;

  logic              idle_like;
  logic [ADDR_W:0]   start_len;
  logic [ADDR_W:0]   pc_inc;
  logic [DATA_W-1:0] rd_data;

  assign idle_like = (state_q == S_IDLE) || (state_q == S_HALT) ||
                     (state_q == S_ERROR);
  assign start_len = (ProgLen > MAX_LEN) ? MAX_LEN : ProgLen;
  assign pc_inc    = {1'b0, pc_q} + (ADDR_W+1)'(1);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    din_d   = din_q;
    unique case (state_q)
      S_IDLE, S_HALT, S_ERROR: begin
        if (Start) begin
          pc_d    = '0;
          len_d   = start_len;
          state_d = (start_len == '0) ? S_HALT : S_FETCH;
        end
      end
      S_FETCH: begin
        din_d   = rd_data;
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Done beats a timeout landing on the same cycle
        if (Done) begin
          if (pc_inc == len_q) begin
            state_d = S_HALT;
          end else begin
            pc_d    = pc_inc[ADDR_W-1:0];
            state_d = S_FETCH;
          end
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d = S_ERROR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Reading at the next PC leaves the word ready when FETCH begins
  prog_ram #(
    .AW(ADDR_W),
    .DW(DATA_W)
  ) u_ram (
    .clk  (Clock),
    .we   (ProgWe && idle_like),
    .waddr(ProgAddr),
    .wdata(ProgData),
    .raddr(pc_d),
    .rdata(rd_data)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      din_q    <= '0;
      run_q    <= 1'b0;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      din_q    <= din_d;
      run_q    <= (state_d == S_ISSUE);
      busy_q   <= (state_d == S_FETCH) || (state_d == S_ISSUE) ||
                  (state_d == S_WAIT);
      halted_q <= (state_d == S_HALT);
      error_q  <= (state_d == S_ERROR);
    end
  end

  assign DIN    = din_q;
  assign Run    = run_q;
  assign PC     = pc_q;
  assign Busy   = busy_q;
  assign Halted = halted_q;
  assign Error  = error_q;

endmodule

// File: tb/tb_instr_fetch_seq.sv
// Directed bench for instr_fetch_seq with a queue of expected
// instruction words popped on every Run pulse.
import proc_pkg::*;

module tb_instr_fetch_seq;

  localparam int AW = 5;
  localparam int DW = 16;

  logic          Clock = 1'b0;
  logic          Reset = 1'b1;
  logic          Start = 1'b0;
  logic [AW:0]   ProgLen = '0;
  logic          ProgWe = 1'b0;
  logic [AW-1:0] ProgAddr = '0;
  logic [DW-1:0] ProgData = '0;
  logic          Done = 1'b0;
  logic [DW-1:0] DIN;
  logic          Run;
  logic [AW-1:0] PC;
  logic          Busy;
  logic          Halted;
  logic          Error;

  instr_fetch_seq #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .TIMEOUT(8)
  ) dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .Start   (Start),
    .ProgLen (ProgLen),
    .ProgWe  (ProgWe),
    .ProgAddr(ProgAddr),
    .ProgData(ProgData),
    .Done    (Done),
    .DIN     (DIN),
    .Run     (Run),
    .PC      (PC),
    .Busy    (Busy),
    .Halted  (Halted),
    .Error   (Error)
  );

  always #5 Clock = ~Clock;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int runs = 0;
  int dbl = 0;
  logic prev_run = 1'b0;
  logic [31:0] sb[$];

  always @(posedge Clock) cyc++;

  always @(negedge Clock) begin
    if (Run) runs++;
    if (Run && prev_run) dbl++;
    prev_run = Run;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic wr(input int a, input logic [DW-1:0] d);
    ProgWe = 1'b1;
    ProgAddr = AW'(a);
    ProgData = d;
    tick();
    ProgWe = 1'b0;
  endtask

  task automatic pulse_start(input int len);
    ProgLen = (AW+1)'(len);
    Start = 1'b1;
    tick();
    Start = 1'b0;
  endtask

  // From FETCH: expects Run on the next cycle with the queued word
  task automatic wait_run(input int exp_pc);
    int w;
    logic [31:0] e;
    w = 0;
    while (!Run && w < 20) begin
      tick();
      w++;
    end
    chk("run_latency", w, 1);
    e = (sb.size() > 0) ? sb.pop_front() : 32'hxxxx_xxxx;
    chk("din", {16'h0, DIN}, e);
    chk("pc_at_run", {27'h0, PC}, exp_pc);
  endtask

  // Core model: Done in the n-th WAIT cycle
  task automatic exec(input int n, input int exp_pc);
    wait_run(exp_pc);
    tick();
    repeat (n - 1) tick();
    Done = 1'b1;
    tick();
    Done = 1'b0;
  endtask

  initial begin
    int t0;
    int r0;

    repeat (3) tick();
    chk("rst_din", {16'h0, DIN}, 0);
    chk("rst_run", Run, 0);
    chk("rst_pc", {27'h0, PC}, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_halted", Halted, 0);
    chk("rst_error", Error, 0);
    Reset = 1'b0;
    tick();

    // Three-instruction program; word 0 written with Start
    wr(0, 16'hAAAA);
    wr(1, 16'h1203);
    wr(2, 16'h4001);
    sb.push_back(32'h1005);
    sb.push_back(32'h1203);
    sb.push_back(32'h4001);
    r0 = runs;
    ProgWe = 1'b1;
    ProgAddr = '0;
    ProgData = 16'h1005;
    pulse_start(3);
    ProgWe = 1'b0;
    t0 = cyc;
    chk("fetch_busy", Busy, 1);
    chk("fetch_run", Run, 0);
    exec(1, 0);
    exec(1, 1);
    exec(3, 2);
    chk("p1_halted", Halted, 1);
    chk("p1_busy", Busy, 0);
    chk("p1_cycles", cyc - t0, 11);
    chk("p1_pc", {27'h0, PC}, 2);
    chk("p1_din_hold", {16'h0, DIN}, 32'h4001);
    chk("p1_runs", runs - r0, 3);

    // Zero length
    r0 = runs;
    pulse_start(0);
    chk("len0_halted", Halted, 1);
    chk("len0_pc", {27'h0, PC}, 0);
    chk("len0_busy", Busy, 0);
    tick();
    chk("len0_runs", runs - r0, 0);

    // Stalled core
    sb.push_back(32'h1005);
    pulse_start(3);
    wait_run(0);
    repeat (8) tick();
    chk("to_not_yet", Error, 0);
    chk("to_busy", Busy, 1);
    tick();
    chk("to_error", Error, 1);
    chk("to_busy_low", Busy, 0);
    chk("to_run", Run, 0);

    // Restart from ERROR with busy write and spurious Done
    sb.push_back(32'h1005);
    pulse_start(3);
    chk("restart_error", Error, 0);
    ProgWe = 1'b1;
    ProgAddr = '0;
    ProgData = 16'hFFFF;
    Done = 1'b1;
    wait_run(0);
    tick();
    Done = 1'b0;
    ProgWe = 1'b0;
    chk("spur_pc", {27'h0, PC}, 0);
    chk("spur_busy", Busy, 1);
    Done = 1'b1;
    tick();
    Done = 1'b0;
    sb.push_back(32'h1203);
    wait_run(1);
    tick();
    tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    chk("midrst_run", Run, 0);
    chk("midrst_pc", {27'h0, PC}, 0);
    chk("midrst_busy", Busy, 0);
    chk("midrst_din", {16'h0, DIN}, 0);

    // Memory survived reset and the dropped write
    sb.push_back(32'h1005);
    sb.push_back(32'h1203);
    sb.push_back(32'h4001);
    pulse_start(3);
    exec(1, 0);
    exec(1, 1);
    exec(3, 2);
    chk("p2_halted", Halted, 1);

    // Full memory, then an over-range length clamped to 32
    for (int i = 0; i < 32; i++) wr(i, {OP_MV, 13'(i)});
    for (int pass = 0; pass < 2; pass++) begin
      r0 = runs;
      for (int i = 0; i < 32; i++) sb.push_back({19'h0, OP_MV, 10'(i)});
      pulse_start(pass == 0 ? 32 : 63);
      for (int i = 0; i < 32; i++) exec(1, i);
      chk("full_halted", Halted, 1);
      chk("full_pc", {27'h0, PC}, 31);
      chk("full_runs", runs - r0, 32);
    end

    chk("sb_empty", sb.size(), 0);
    chk("run_no_double", dbl, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
